bp_update_scheduler: RTL and testbench

Sequences all write traffic into the branch predictor's BTB and BHT/GHR update port. After reset it runs an invalidation sweep over every BTB index. It then buffers branch resolutions from the execute stage in a small FIFO and drains them one per cycle. Drains are yielded to fetch-side lookups, and a starvation counter guarantees forward progress. It sits between the execute stage and the predictor's update inputs.

---
 rtl/bp_update_scheduler.sv | 113 +++++++++++
 tb/tb_bp_update_scheduler.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// Write-port sequencer for the branch predictor: a BTB invalidation sweep after reset,
// then in-order draining of buffered branch resolutions with a fetch-yield starvation guard.
module bp_update_scheduler #(
    parameter int NUM_BTB_ENTRIES = 16,
    parameter int DEPTH           = 4,
    parameter int TARGET_WIDTH    = 32,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ex_valid,
    input  logic [31:0]                        ex_pc,
    input  logic                               ex_taken,
    input  logic [TARGET_WIDTH-1:0]            ex_imm,
    output logic                               ex_ready,
    output logic                               ex_drop,
    input  logic                               fetch_busy,
    output logic                               upd_valid,
    output logic [31:0]                        upd_pc,
    output logic                               upd_taken,
    output logic [TARGET_WIDTH-1:0]            upd_imm,
    output logic                               upd_clear,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] upd_index,
    output logic                               init_done
);
    localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [31:0]             pc;
        logic                    taken;
        logic [TARGET_WIDTH-1:0] imm;
    } entry_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_idx;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [SC_W-1:0]  starve_cnt;
    entry_t           mem [DEPTH];

    logic   empty;
    logic   full;
    logic   push;
    logic   grant;
    logic   starved;
    entry_t head;

    always_comb begin
        empty     = (count == '0);
        full      = (count == CNT_W'(DEPTH));
        starved   = (starve_cnt == SC_W'(STARVE_LIMIT));
        ex_ready  = (state == RUN) && !full;
        ex_drop   = ex_valid && !ex_ready;
        push      = ex_valid && ex_ready;
        grant     = (state == RUN) && !empty && (!fetch_busy || starved);
        head      = mem[rd_ptr];
        upd_valid = grant;
        // Gate the payload so an unwritten FIFO slot never leaks X onto the update bus.
        upd_pc    = grant ? head.pc : '0;
        upd_taken = grant ? head.taken : 1'b0;
        upd_imm   = grant ? head.imm : '0;
        upd_clear = (state == INIT);
        upd_index = (state == INIT) ? sweep_idx : '0;
        init_done = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            sweep_idx  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    // Index wraps back to 0 on the last entry, leaving it ready for the next sweep.
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == IDX_W'(NUM_BTB_ENTRIES - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (push)
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    if (grant)
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    if (push && !grant)
                        count <= count + CNT_W'(1);
                    else if (!push && grant)
                        count <= count - CNT_W'(1);
                    if (grant || empty)
                        starve_cnt <= '0;
                    else if (fetch_busy && !starved)
                        starve_cnt <= starve_cnt + SC_W'(1);
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: ex_pc, taken: ex_taken, imm: ex_imm};
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed-plus-random bench for bp_update_scheduler against a queue-based reference model.
module tb_bp_update_scheduler;
    localparam int NB = 16;
    localparam int DP = 4;
    localparam int TW = 32;
    localparam int SL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic [31:0]   ex_pc = '0;
    logic          ex_taken = 1'b0;
    logic [TW-1:0] ex_imm = '0;
    logic          ex_ready;
    logic          ex_drop;
    logic          fetch_busy = 1'b0;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_taken;
    logic [TW-1:0] upd_imm;
    logic          upd_clear;
    logic [$clog2(NB)-1:0] upd_index;
    logic          init_done;

    bp_update_scheduler #(
        .NUM_BTB_ENTRIES(NB), .DEPTH(DP), .TARGET_WIDTH(TW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_imm(ex_imm),
        .ex_ready(ex_ready), .ex_drop(ex_drop), .fetch_busy(fetch_busy),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_imm(upd_imm),
        .upd_clear(upd_clear), .upd_index(upd_index), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic          taken;
        logic [TW-1:0] imm;
    } ent_t;

    ent_t q[$];
    bit   m_run;
    int   m_sweep;
    int   m_wait;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check mid-cycle, then advance the model.
    task automatic step(input logic r, input logic v, input logic [31:0] pc,
                        input logic t, input logic [TW-1:0] imm, input logic fb);
        bit   e_ready, e_grant;
        ent_t e;
        @(posedge clk);
        #1;
        rst = r; ex_valid = v; ex_pc = pc; ex_taken = t; ex_imm = imm; fetch_busy = fb;
        #3;
        e_ready = m_run && (q.size() < DP);
        e_grant = m_run && (q.size() > 0) && (!fb || m_wait == SL);
        chk("upd_clear", 64'(upd_clear), 64'(!m_run));
        chk("upd_index", 64'(upd_index), m_run ? 64'd0 : 64'(m_sweep));
        chk("init_done", 64'(init_done), 64'(m_run));
        chk("ex_ready", 64'(ex_ready), 64'(e_ready));
        chk("ex_drop", 64'(ex_drop), 64'(v && !e_ready));
        chk("upd_valid", 64'(upd_valid), 64'(e_grant));
        if (e_grant) begin
            e = q[0];
            chk("upd_pc", 64'(upd_pc), 64'(e.pc));
            chk("upd_taken", 64'(upd_taken), 64'(e.taken));
            chk("upd_imm", 64'(upd_imm), 64'(e.imm));
        end else begin
            chk("upd_noX", 64'(^{upd_pc, upd_taken, upd_imm} === 1'bx), 64'd0);
        end
        if (r) begin
            m_run = 0; m_sweep = 0; m_wait = 0; q.delete();
        end else if (!m_run) begin
            if (m_sweep == NB - 1) begin m_run = 1; m_sweep = 0; end
            else m_sweep++;
        end else begin
            if (e_grant) begin void'(q.pop_front()); m_wait = 0; end
            else if (q.size() > 0 && fb) m_wait++;
            else m_wait = 0;
            if (v && e_ready) q.push_back('{pc: pc, taken: t, imm: imm});
        end
    endtask

    task automatic idle(input int n, input logic fb);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, '0, fb);
    endtask

    task automatic rpush(input logic fb);
        step(1'b0, 1'b1, $urandom, 1'($urandom), TW'($urandom), fb);
    endtask

    initial begin
        @(posedge clk);
        m_run = 0; m_sweep = 0; m_wait = 0; q.delete();
        // Reset held, then sweep with stray ex_valid that must be dropped.
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b1);
        for (int i = 0; i < NB; i++)
            step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b1, TW'($urandom), 1'($urandom_range(0, 1)));
        idle(2, 1'b0);
        // Order and latency.
        step(1'b0, 1'b1, 32'h100, 1'b1, TW'(32'h40), 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b0, TW'(32'h8), 1'b0);
        idle(3, 1'b0);
        // Full / drop with fetch_busy high.
        for (int i = 0; i < 5; i++) rpush(1'b1);
        idle(8, 1'b1);
        idle(5, 1'b0);
        // Starvation of a single entry.
        rpush(1'b1);
        idle(7, 1'b1);
        // Wrap-around with alternating fetch_busy.
        for (int i = 0; i < 12; i++) rpush(1'(i % 2));
        idle(6, 1'b0);
        // Random traffic.
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom), TW'($urandom),
                 1'($urandom_range(0, 3) != 0));
        idle(6, 1'b0);
        // Mid-run reset with queued entries.
        for (int i = 0; i < 3; i++) rpush(1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b0);
        for (int i = 0; i < NB + 4; i++)
            step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom), TW'($urandom), 1'b0);
        idle(4, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
